sobel_frame_sequencer: RTL and testbench

SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sobel_pixel_counter.sv | 64 ++++++
 rtl/sobel_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared geometry defaults and sequencer state encoding
package sobel_pkg;

   localparam int DEF_IMG_W  = 320;
   localparam int DEF_IMG_H  = 240;
   localparam int DEF_PX_W   = 15;
   localparam int DEF_ADDR_W = 17;

   localparam int ROW_W = 8;
   localparam int COL_W = 9;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      ISSUE    = 3'd2,
      WAIT_RES = 3'd3,
      STORE    = 3'd4,
      DONE     = 3'd5
   } seq_state_e;

endpackage

// File: rtl/sobel_pixel_counter.sv
// rtl/sobel_pixel_counter.sv - raster address/row/column counter with last-pixel flag
module sobel_pixel_counter
   import sobel_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ROW_W-1:0]  row_o,
   output logic [COL_W-1:0]  col_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ROW_W-1:0]  row_q,  row_d;
   logic [COL_W-1:0]  col_q,  col_d;

   assign last_o = (addr_q == LAST_ADDR);
   assign addr_o = addr_q;
   assign row_o  = row_q;
   assign col_o  = col_q;

   // Clear wins over increment; the count never advances past the last pixel.
   always_comb begin
      addr_d = addr_q;
      row_d  = row_q;
      col_d  = col_q;
      if (clr_i) begin
         addr_d = '0;
         row_d  = '0;
         col_d  = '0;
      end else if (inc_i && !last_o) begin
         addr_d = addr_q + 1'b1;
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         addr_q <= addr_d;
         row_q  <= row_d;
         col_q  <= col_d;
      end
   end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// rtl/sobel_frame_sequencer.sv - walks one frame through fetch, sobel core and write-back
module sobel_frame_sequencer
   import sobel_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int PX_W   = DEF_PX_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              sobel_clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [PX_W-1:0]   px_in,
   output logic              core_valid,
   output logic [PX_W-1:0]   core_px,
   input  logic              core_ready,
   input  logic              res_valid,
   input  logic [PX_W-1:0]   res_px,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PX_W-1:0]   wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic              frame_done,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col
);

   seq_state_e        state_q, state_d;
   logic [PX_W-1:0]   core_px_q;
   logic [PX_W-1:0]   wr_data_q;
   logic [ADDR_W-1:0] addr;
   logic              last_px;
   logic              cnt_clr;
   logic              cnt_inc;

   sobel_pixel_counter #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_counter (
      .clk_i  (sobel_clk),
      .rst_i  (reset),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .addr_o (addr),
      .row_o  (row),
      .col_o  (col),
      .last_o (last_px)
   );

   // State register.
   always_ff @(posedge sobel_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and counter control; abort overrides every handshake outside IDLE.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (state_q == IDLE) begin
         if (start && !abort) begin
            state_d = FETCH;
            cnt_clr = 1'b1;
         end
      end else if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            FETCH:    if (rd_ack)     state_d = ISSUE;
            ISSUE:    if (core_ready) state_d = WAIT_RES;
            WAIT_RES: if (res_valid)  state_d = STORE;
            STORE: begin
               if (wr_ack) begin
                  if (last_px) begin
                     state_d = DONE;
                  end else begin
                     state_d = FETCH;
                     cnt_inc = 1'b1;
                  end
               end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      rd_req     = 1'b0;
      core_valid = 1'b0;
      wr_en      = 1'b0;
      frame_done = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         FETCH:   rd_req     = 1'b1;
         ISSUE:   core_valid = 1'b1;
         STORE:   wr_en      = 1'b1;
         DONE:    frame_done = 1'b1;
         default: ;
      endcase
   end

   // Pixel and result holding registers; they only load on the handshake of their own state.
   always_ff @(posedge sobel_clk or posedge reset) begin
      if (reset) begin
         core_px_q <= '0;
         wr_data_q <= '0;
      end else begin
         if (state_q == FETCH && rd_ack && !abort) begin
            core_px_q <= px_in;
         end
         if (state_q == WAIT_RES && res_valid && !abort) begin
            wr_data_q <= res_px;
         end
      end
   end

   assign rd_addr = addr;
   assign wr_addr = addr;
   assign core_px = core_px_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb/tb_sobel_frame_sequencer.sv - directed vector and sequence bench for sobel_frame_sequencer
module tb_sobel_frame_sequencer;

   localparam int IMG_W  = 320;
   localparam int IMG_H  = 4;
   localparam int PX_W   = 15;
   localparam int ADDR_W = 17;
   localparam int NPIX   = IMG_W * IMG_H;

   logic              clk;
   logic              rst;
   logic              start, abort, rd_ack, core_ready, res_valid, wr_ack;
   logic              rd_req, core_valid, wr_en, busy, frame_done;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [PX_W-1:0]   px_in, res_px, core_px, wr_data;
   logic [7:0]        row;
   logic [8:0]        col;

   int n_checks = 0;
   int n_pass   = 0;

   sobel_frame_sequencer #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .PX_W   (PX_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .sobel_clk  (clk),
      .reset      (rst),
      .start      (start),
      .abort      (abort),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .px_in      (px_in),
      .core_valid (core_valid),
      .core_px    (core_px),
      .core_ready (core_ready),
      .res_valid  (res_valid),
      .res_px     (res_px),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .busy       (busy),
      .frame_done (frame_done),
      .row        (row),
      .col        (col)
   );

   // Input buffer returns the low address bits; the core is a loopback.
   assign px_in  = rd_addr[PX_W-1:0];
   assign res_px = core_px;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic set_in(input logic [5:0] v);
      {start, abort, rd_ack, core_ready, res_valid, wr_ack} = v;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      set_in(6'b000000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [5:0] in_v;    // start, abort, rd_ack, core_ready, res_valid, wr_ack
      logic [4:0] flags;   // rd_req, core_valid, wr_en, busy, frame_done
      int         addr;
      int         cpx;
      int         wdat;
   } vec_t;

   vec_t vecs[17];

   int cyc, done_cyc, nwr, order_err, r319, c319, r320, c320;
   int stall_cnt, stab_err, phase, fd_seen, wr321, found;

   initial begin
      vecs[0]  = '{6'b001111, 5'b00000, 0, 0, 0};  // idle ignores handshakes
      vecs[1]  = '{6'b110000, 5'b00000, 0, 0, 0};  // start+abort in idle
      vecs[2]  = '{6'b100000, 5'b10010, 0, 0, 0};  // start -> FETCH
      vecs[3]  = '{6'b000111, 5'b10010, 0, 0, 0};  // FETCH waits for rd_ack
      vecs[4]  = '{6'b101000, 5'b01010, 0, 0, 0};  // rd_ack, start ignored
      vecs[5]  = '{6'b001011, 5'b01010, 0, 0, 0};  // ISSUE waits for core_ready
      vecs[6]  = '{6'b000100, 5'b00010, 0, 0, 0};  // -> WAIT_RES
      vecs[7]  = '{6'b001101, 5'b00010, 0, 0, 0};  // waits for res_valid
      vecs[8]  = '{6'b000010, 5'b00110, 0, 0, 0};  // -> STORE
      vecs[9]  = '{6'b001110, 5'b00110, 0, 0, 0};  // waits for wr_ack
      vecs[10] = '{6'b000001, 5'b10010, 1, 0, 0};  // next pixel
      vecs[11] = '{6'b001000, 5'b01010, 1, 1, 0};
      vecs[12] = '{6'b000100, 5'b00010, 1, 1, 0};
      vecs[13] = '{6'b000010, 5'b00110, 1, 1, 1};
      vecs[14] = '{6'b010001, 5'b00000, 1, 1, 1};  // abort beats wr_ack
      vecs[15] = '{6'b100000, 5'b10010, 0, 1, 1};  // restart at 0
      vecs[16] = '{6'b011000, 5'b00000, 0, 1, 1};  // abort beats rd_ack

      rst = 1'b1;
      set_in(6'b000000);
      repeat (2) @(negedge clk);
      check("reset_flags", {rd_req, core_valid, wr_en, busy, frame_done}, 5'b00000);
      check("reset_addr", {rd_addr, wr_addr}, 0);
      check("reset_data", {core_px, wr_data}, 0);
      check("reset_rowcol", {row, col}, 0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         set_in(vecs[i].in_v);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_flags", i), {rd_req, core_valid, wr_en, busy, frame_done}, vecs[i].flags);
         check($sformatf("vec%0d_addr", i), rd_addr, vecs[i].addr);
         check($sformatf("vec%0d_core_px", i), core_px, vecs[i].cpx);
         check($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].wdat);
         @(negedge clk);
      end

      // Full frame with every handshake immediate.
      do_reset();
      set_in(6'b101111);
      @(posedge clk);
      cyc = 0; done_cyc = -1; nwr = 0; order_err = 0;
      r319 = -1; c319 = -1; r320 = -1; c320 = -1;
      while (cyc < 4 * NPIX + 20 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         start = (cyc == 40);
         if (wr_en) begin
            if (int'(wr_addr) != nwr || wr_data != wr_addr[PX_W-1:0]) order_err++;
            nwr++;
         end
         if (rd_req && rd_addr == 319) begin r319 = row; c319 = col; end
         if (rd_req && rd_addr == 320) begin r320 = row; c320 = col; end
         if (frame_done) done_cyc = cyc;
      end
      check("frame_done_cycle", done_cyc, 4 * NPIX + 1);
      check("frame_write_count", nwr, NPIX);
      check("frame_write_order_data", order_err, 0);
      check("rowcol_px319", {r319[15:0], c319[15:0]}, {16'd0, 16'd319});
      check("rowcol_px320", {r320[15:0], c320[15:0]}, {16'd1, 16'd0});
      @(negedge clk);
      check("after_done", {busy, frame_done}, 2'b00);

      // Core stall at pixel 10, then abort in WAIT_RES at pixel 321.
      do_reset();
      set_in(6'b101111);
      cyc = 0; nwr = 0; order_err = 0; stall_cnt = 0; stab_err = 0;
      phase = 0; fd_seen = 0; wr321 = 0;
      while (cyc < 4 * 400 && phase < 3) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (frame_done) fd_seen++;
         if (wr_en) begin
            if (wr_addr == 321) wr321++;
            if (int'(wr_addr) != nwr || wr_data != wr_addr[PX_W-1:0]) order_err++;
            nwr++;
         end
         if (core_valid && rd_addr == 10) begin
            stall_cnt++;
            if (core_px != 15'd10) stab_err++;
            if (stall_cnt == 6) core_ready = 1'b1;
         end
         if (rd_req && rd_addr == 10) core_ready = 1'b0;
         case (phase)
            0: if (core_valid && rd_addr == 321) phase = 1;
            1: begin
               check("wait_res_before_abort", {busy, rd_req, core_valid, wr_en}, 4'b1000);
               abort = 1'b1;
               phase = 2;
            end
            2: begin
               check("abort_to_idle", {busy, frame_done, wr_en}, 3'b000);
               abort = 1'b0;
               phase = 3;
            end
            default: ;
         endcase
      end
      check("abort_reached", phase, 3);
      check("stall_valid_cycles", stall_cnt, 6);
      check("stall_core_px_stable", stab_err, 0);
      check("abort_write_count", nwr, 321);
      check("abort_write_order", order_err, 0);
      check("abort_no_write_321", wr321, 0);
      check("abort_no_frame_done", fd_seen, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_fetch", {rd_req, busy}, 2'b11);
      check("restart_pos", {rd_addr, row, col}, 0);

      // Asynchronous reset while a write is pending.
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         if (wr_en && wr_addr == 5) found = 1;
      end
      check("store_px5_reached", found, 1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_flags", {rd_req, core_valid, wr_en, busy, frame_done}, 5'b00000);
      check("async_rst_addr", {rd_addr, wr_addr}, 0);
      check("async_rst_data", {core_px, wr_data}, 0);
      check("async_rst_rowcol", {row, col}, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("post_rst_start", {rd_req, rd_addr}, {1'b1, 17'd0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
